// File: rtl/unpacked_lane_fifo_if.sv
// Handshake bundle for unpacked_lane_fifo: producer side (in_*), consumer side (out_*) and fill level.
// The fifo uses the slave modport; the driving environment uses master.
interface unpacked_lane_fifo_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]           in_data  [LANES-1:0];
  logic [1:0]                 in_mode;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           out_data [LANES-1:0];
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/unpacked_lane_fifo.sv
// Multi-lane FIFO with per-beat transform on write (pass / invert / reverse / invert+reverse).
// Lane reversal for modes 2 and 3 is built only when UNPACKED_LANE_FIFO_REVERSE_EN is defined.
module unpacked_lane_fifo #(
  parameter int LANES = 8,
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  unpacked_lane_fifo_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH-1:0][LANES-1:0];
  logic [WIDTH-1:0] t   [LANES-1:0];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // Handshake outputs depend only on registered count, never on in_valid/out_ready.
  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

`ifndef UNPACKED_LANE_FIFO_REVERSE_EN
  logic mode_hi_unused;
  assign mode_hi_unused = bus.in_mode[1];
`endif

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      t[i] = bus.in_data[i];
`ifdef UNPACKED_LANE_FIFO_REVERSE_EN
      if (bus.in_mode[1]) t[i] = bus.in_data[LANES-1-i];
`endif
      if (bus.in_mode[0]) t[i] = ~t[i];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      bus.out_data[i] = bus.out_valid ? mem[rd_ptr][i] : '0;
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      for (int i = 0; i < LANES; i++) begin
        mem[wr_ptr][i] <= t[i];
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
